// File: rtl/ibex_pkg.sv
// Shared types for the writeback queue: instruction class and per-entry payload.
package ibex_pkg;

  typedef enum logic [1:0] {
    WB_INSTR_LOAD  = 2'b00,
    WB_INSTR_STORE = 2'b01,
    WB_INSTR_OTHER = 2'b10
  } wb_instr_type_e;

  // Valid bits live beside the array so only they need a reset.
  typedef struct packed {
    wb_instr_type_e itype;
    logic [31:0]    pc;
    logic           compressed;
    logic           count;
    logic           we;
    logic [4:0]     waddr;
    logic [31:0]    wdata;
  } wb_entry_t;

endpackage

// File: rtl/ibex_wb_fwd_lookup.sv
// Youngest-match search over the writeback queue for one register read port.
module ibex_wb_fwd_lookup import ibex_pkg::*; #(
  parameter int unsigned WbDepth = 2,
  parameter int unsigned PtrW    = 1
) (
  input  wb_entry_t              entries_i [WbDepth],
  input  logic [WbDepth-1:0]     valid_i,
  input  logic [PtrW-1:0]        head_i,
  input  logic [4:0]             raddr_i,
  output logic                   hit_o,
  output logic [31:0]            data_o,
  output logic                   stall_o
);

  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DEPTH = CntW'(WbDepth);

  logic [CntW-1:0] sum;
  logic [PtrW-1:0] idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit_o   = 1'b0;
    data_o  = '0;
    stall_o = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int unsigned i = 0; i < WbDepth; i++) begin
      sum = {1'b0, head_i} + CntW'(i);
      if (sum >= DEPTH) begin
        sum = sum - DEPTH;
      end
      idx = sum[PtrW-1:0];
      if (valid_i[idx] && (raddr_i != 5'd0) && (entries_i[idx].waddr == raddr_i) &&
          (entries_i[idx].we || (entries_i[idx].itype == WB_INSTR_LOAD))) begin
        hit_o   = 1'b0;
        data_o  = '0;
        stall_o = 1'b0;
        if (entries_i[idx].itype == WB_INSTR_LOAD) begin
          stall_o = 1'b1;
        end else if (entries_i[idx].itype == WB_INSTR_OTHER) begin
          hit_o  = 1'b1;
          data_o = entries_i[idx].wdata;
        end
      end
    end
  end

endmodule

// File: rtl/ibex_wb_queue.sv
// In-order multi-entry writeback buffer with result forwarding and load-use stall detection.
module ibex_wb_queue import ibex_pkg::*; #(
  parameter int unsigned WbDepth = 2,
  localparam int unsigned PtrW   = (WbDepth > 1) ? $clog2(WbDepth) : 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           en_wb_i,
  input  wb_instr_type_e instr_type_wb_i,
  input  logic [31:0]    pc_id_i,
  input  logic           instr_is_compressed_id_i,
  input  logic           instr_perf_count_id_i,
  input  logic [4:0]     rf_waddr_id_i,
  input  logic [31:0]    rf_wdata_id_i,
  input  logic           rf_we_id_i,
  input  logic [31:0]    rf_wdata_lsu_i,
  input  logic           rf_we_lsu_i,
  input  logic           lsu_resp_valid_i,
  input  logic           lsu_resp_err_i,
  input  logic [4:0]     rf_raddr_a_i,
  input  logic [4:0]     rf_raddr_b_i,
  output logic           ready_wb_o,
  output logic           fwd_hit_a_o,
  output logic           fwd_hit_b_o,
  output logic [31:0]    fwd_data_a_o,
  output logic [31:0]    fwd_data_b_o,
  output logic           stall_a_o,
  output logic           stall_b_o,
  output logic           outstanding_load_wb_o,
  output logic           outstanding_store_wb_o,
  output logic [PtrW:0]  occupancy_o,
  output logic [31:0]    pc_wb_o,
  output logic [4:0]     rf_waddr_wb_o,
  output logic [31:0]    rf_wdata_wb_o,
  output logic           rf_we_wb_o,
  output logic           instr_done_wb_o,
  output logic           perf_instr_ret_wb_o,
  output logic           perf_instr_ret_compressed_wb_o
);

  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DEPTH = CntW'(WbDepth);
  localparam logic [PtrW-1:0] LAST  = PtrW'(WbDepth - 1);

  wb_entry_t          entries_q [WbDepth];
  logic [WbDepth-1:0] valid_q;
  logic [PtrW-1:0]    head_q, tail_q;
  logic [CntW-1:0]    count_q;

  wb_entry_t head_ent, new_ent;
  logic      head_valid, head_is_other, head_done, push, we_q_path;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign head_ent      = entries_q[head_q];
  assign head_valid    = valid_q[head_q];
  assign head_is_other = head_ent.itype == WB_INSTR_OTHER;
  assign head_done     = head_valid & (head_is_other | lsu_resp_valid_i);
  assign ready_wb_o    = (count_q < DEPTH) | head_done;
  assign push          = en_wb_i & ready_wb_o;

  always_comb begin
    new_ent            = '0;
    new_ent.itype      = instr_type_wb_i;
    new_ent.pc         = pc_id_i;
    new_ent.compressed = instr_is_compressed_id_i;
    new_ent.count      = instr_perf_count_id_i;
    new_ent.we         = rf_we_id_i;
    new_ent.waddr      = rf_waddr_id_i;
    new_ent.wdata      = rf_wdata_id_i;
  end

  // Push is applied after retire so a full queue can refill the slot it just freed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (head_done) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= ptr_inc(head_q);
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= ptr_inc(tail_q);
      end
      if (push && !head_done) begin
        count_q <= count_q + 1'b1;
      end else if (!push && head_done) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      entries_q[tail_q] <= new_ent;
    end
  end

  always_comb begin
    outstanding_load_wb_o  = 1'b0;
    outstanding_store_wb_o = 1'b0;
    for (int unsigned i = 0; i < WbDepth; i++) begin
      if (valid_q[i] && (entries_q[i].itype == WB_INSTR_LOAD)) begin
        outstanding_load_wb_o = 1'b1;
      end
      if (valid_q[i] && (entries_q[i].itype == WB_INSTR_STORE)) begin
        outstanding_store_wb_o = 1'b1;
      end
    end
  end

  assign we_q_path       = head_valid & head_ent.we & head_is_other;
  assign rf_we_wb_o      = we_q_path | rf_we_lsu_i;
  assign rf_wdata_wb_o   = we_q_path ? head_ent.wdata : rf_wdata_lsu_i;
  assign rf_waddr_wb_o   = head_valid ? head_ent.waddr : 5'd0;
  assign pc_wb_o         = head_valid ? head_ent.pc : 32'd0;
  assign instr_done_wb_o = head_done;
  assign occupancy_o     = count_q;

  assign perf_instr_ret_wb_o =
      head_done & head_ent.count & ~(lsu_resp_valid_i & lsu_resp_err_i);
  assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & head_ent.compressed;

  ibex_wb_fwd_lookup #(
    .WbDepth (WbDepth),
    .PtrW    (PtrW)
  ) u_fwd_a (
    .entries_i (entries_q),
    .valid_i   (valid_q),
    .head_i    (head_q),
    .raddr_i   (rf_raddr_a_i),
    .hit_o     (fwd_hit_a_o),
    .data_o    (fwd_data_a_o),
    .stall_o   (stall_a_o)
  );

  ibex_wb_fwd_lookup #(
    .WbDepth (WbDepth),
    .PtrW    (PtrW)
  ) u_fwd_b (
    .entries_i (entries_q),
    .valid_i   (valid_q),
    .head_i    (head_q),
    .raddr_i   (rf_raddr_b_i),
    .hit_o     (fwd_hit_b_o),
    .data_o    (fwd_data_b_o),
    .stall_o   (stall_b_o)
  );

  a_no_enq_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    en_wb_i |-> ready_wb_o);
  a_single_rf_writer: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({we_q_path, rf_we_lsu_i}));
  a_lsu_resp_has_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lsu_resp_valid_i |-> (head_valid && !head_is_other));

endmodule

// File: doc/ibex_wb_queue.md
Name: ibex_wb_queue

Overview:
- Multi-entry, in-order writeback buffer between ID/EX and the register file.
- Generalises the single-slot writeback stage: up to WbDepth instructions (loads, stores, ALU results) may be in flight.
- Retires in program order, one instruction per cycle max.
- Forwards the youngest matching ALU result to ID/EX and flags load-use hazards per read port.
- WbDepth=1 is cycle-equivalent to the existing single-slot stage.

Parameters:
WbDepth, 2, number of buffer entries; legal 1..4.
PtrW, $clog2(WbDepth) (min 1), pointer width; derived, not overridable.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
en_wb_i  in  1  ID/EX presents an instruction for writeback
instr_type_wb_i  in  wb_instr_type_e  LOAD / STORE / OTHER
pc_id_i  in  32  PC of incoming instruction
instr_is_compressed_id_i  in  1  incoming instruction is compressed
instr_perf_count_id_i  in  1  incoming instruction counts toward retire counters
rf_waddr_id_i  in  5  destination register
rf_wdata_id_i  in  32  ALU/CSR result
rf_we_id_i  in  1  incoming instruction writes RF from ID result
rf_wdata_lsu_i  in  32  load data
rf_we_lsu_i  in  1  LSU load-data write request
lsu_resp_valid_i  in  1  LSU response for oldest outstanding load/store
lsu_resp_err_i  in  1  that response carries a bus error
rf_raddr_a_i  in  5  ID read-port A address
rf_raddr_b_i  in  5  ID read-port B address
ready_wb_o  out  1  queue can accept an instruction this cycle
fwd_hit_a_o  out  1  port A forwarded from queue
fwd_hit_b_o  out  1  port B forwarded from queue
fwd_data_a_o  out  32  port A forward data
fwd_data_b_o  out  32  port B forward data
stall_a_o  out  1  port A depends on a pending load
stall_b_o  out  1  port B depends on a pending load
outstanding_load_wb_o  out  1  any valid LOAD entry
outstanding_store_wb_o  out  1  any valid STORE entry
occupancy_o  out  PtrW+1  valid entry count
pc_wb_o  out  32  PC of head entry
rf_waddr_wb_o  out  5  RF write address
rf_wdata_wb_o  out  32  RF write data
rf_we_wb_o  out  1  RF write enable
instr_done_wb_o  out  1  head entry retires this cycle
perf_instr_ret_wb_o  out  1  retire-counter increment
perf_instr_ret_compressed_wb_o  out  1  compressed retire-counter increment

Behaviour:
- Storage: circular buffer of WbDepth entries {valid, type, pc, compressed, count, we, waddr, wdata}.
  - head/tail pointers wrap at WbDepth (non-power-of-2 safe); count register 0..WbDepth.
  - Reset: all valid=0, head=tail=count=0. Payload flops not reset.
- head_done = head.valid & (head.type==OTHER | lsu_resp_valid_i).
  - instr_done_wb_o = head_done; on done: head.valid<=0, head++.
- ready_wb_o = (count<WbDepth) | head_done. Combinational path from lsu_resp_valid_i is accepted.
- Enqueue on en_wb_i & ready_wb_o: write tail entry, tail++.
  - Simultaneous enqueue+retire: count unchanged.
  - Full+retire: the freed head slot may be the new tail.
  - en_wb_i while !ready_wb_o is illegal (assert).
- Latency: an OTHER instruction enqueued in cycle N with empty queue retires and writes RF in cycle N+1.
- RF write:
  - we_q_path = head.valid & head.we & head.type==OTHER.
  - rf_we_wb_o = we_q_path | rf_we_lsu_i.
  - data = we_q_path ? head.wdata : rf_wdata_lsu_i; rf_waddr_wb_o = head.waddr.
  - Assert $onehot0({we_q_path, rf_we_lsu_i}).
  - Assert lsu_resp_valid_i -> head.valid & head.type!=OTHER.
- Perf:
  - perf_instr_ret_wb_o = head_done & head.count & ~(lsu_resp_valid_i & lsu_resp_err_i).
  - perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & head.compressed.
- Forwarding, per port X:
  - Scan valid entries youngest to oldest; select the youngest with waddr==raddr_X and (we | type==LOAD). raddr_X==0 never matches.
  - Selected entry OTHER with we: fwd_hit_X_o=1, fwd_data_X_o=wdata, stall_X_o=0.
  - Selected entry LOAD: stall_X_o=1, fwd_hit_X_o=0.
  - No match: all outputs 0 (data 0).
  - An entry retiring this cycle still forwards; the RF is updated at the next edge.
- Reset while mid-operation: all entries are dropped and the outputs below return to 0 immediately (async). No pending LSU response is remembered.
- Reset values: ready_wb_o=1; rf_we_wb_o=rf_we_lsu_i; all other outputs 0.
  - pc_wb_o, rf_waddr_wb_o and rf_wdata_wb_o are don't-care while rf_we_wb_o=0.

Decomposition:
- ibex_pkg: wb_instr_type_e (existing), plus new packed struct wb_entry_t holding the entry payload.
- Sub-module ibex_wb_fwd_lookup: combinational youngest-match search. Instantiated once per read port; inputs are entry array, head pointer, raddr.

Test Plan:
1. WbDepth=2, reset; enqueue OTHER we=1 waddr=5 data=0xDEADBEEF -> next cycle rf_we_wb_o=1, waddr=5, data=0xDEADBEEF, instr_done=1, occupancy returns to 0.
2. Enqueue LOAD x7 then OTHER x8=0x11, no LSU resp:
   - occupancy=2, ready=0; raddr_a=7 -> stall_a=1; raddr_b=8 -> fwd_hit_b=1, data 0x11.
   - lsu_resp_valid+rf_we_lsu (0x22) -> RF write x7=0x22, ready=1.
   - Next cycle x8=0x11 written.
3. Two OTHER writes to x3 (0x1 then 0x2) queued behind a STORE; raddr_a=3 -> fwd_data_a=0x2 (youngest wins); raddr_a=0 -> no hit.
4. Full queue; same cycle lsu_resp_valid and en_wb_i -> head retires, new entry accepted into freed slot, occupancy stays WbDepth, pointer wrap verified.
5. LOAD with lsu_resp_err=1, count=1 -> instr_done=1, perf_instr_ret=0, rf_we_wb_o=0.
6. Assert rst_ni low with 2 valid entries -> occupancy=0, outstanding_load=0, ready=1 asynchronously. The first instruction enqueued after reset retires alone.
